isr_priority_resolver: RTL and testbench

ISR_PRIORITY_RESOLVER -- requirements
Module: isr_priority_resolver

---
 rtl/isr_priority_resolver_pkg.sv | 19 +
 rtl/isr_priority_resolver_prio_encoder_rot.sv | 27 ++
 rtl/isr_priority_resolver.sv | 186 ++++++++++++++++++
 tb/tb_isr_priority_resolver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isr_priority_resolver_pkg.sv
// rtl/isr_priority_resolver_pkg.sv - shared types and constants for the interrupt priority resolver
package isr_priority_resolver_pkg;

   localparam int         NUM_IR         = 8;
   localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
   localparam logic [2:0] LP_RESET       = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } ack_state_t;

   // Rank of a level under lowest-priority pointer lp: 0 is the highest priority.
   function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lp);
      return level - lp - 3'd1;
   endfunction

endpackage

// File: rtl/isr_priority_resolver_prio_encoder_rot.sv
// rtl/isr_priority_resolver_prio_encoder_rot.sv - rotated priority encoder, search starts at lp+1
module prio_encoder_rot
   import isr_priority_resolver_pkg::*;
(
   input  logic [NUM_IR-1:0] vector,
   input  logic [2:0]        lp,
   output logic              found,
   output logic [2:0]        level
);

   logic [2:0] idx;

   // Walk from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      found = 1'b0;
      level = SPURIOUS_LEVEL;
      idx   = lp;
      for (int i = NUM_IR; i >= 1; i--) begin
         idx = lp + 3'(i);
         if (vector[idx]) begin
            found = 1'b1;
            level = idx;
         end
      end
   end

endmodule

// File: rtl/isr_priority_resolver.sv
// rtl/isr_priority_resolver.sv - in-service/priority resolver with INTA handshake; ISR_AUTO_EOI_EN enables auto EOI
module isr_priority_resolver
   import isr_priority_resolver_pkg::*;
#(
   parameter logic [4:0] VECTOR_BASE = 5'b00001
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  irr,
   input  logic [7:0]  imr,
   input  logic        inta_n,
   input  logic        eoi_valid,
   input  logic        eoi_specific,
   input  logic [2:0]  eoi_level,
   input  logic        rotate_en,
   output logic        int_out,
   output logic [7:0]  isr,
   output logic [7:0]  irr_clear,
   output logic        vector_valid,
   output logic [7:0]  vector
);

   ack_state_t state_q, state_d;
   logic       inta_q;
   logic       ack_edge;
   logic       enter_ack1;
   logic       enter_ack2;
   logic [2:0] lp_q;
   logic [2:0] lp_d;
   logic [2:0] lp_eff;
   logic [2:0] level_q;
   logic [7:0] eligible;
   logic       req_found;
   logic [2:0] req_level;
   logic       isr_found;
   logic [2:0] isr_level;
   logic [7:0] set_mask;
   logic [7:0] clr_mask;
   logic       int_out_d;
`ifdef ISR_AUTO_EOI_EN
   logic       spurious_q;
`endif

   // Fixed mode is rotating mode with the pointer parked at 7, so IR0 leads.
   assign lp_eff   = rotate_en ? lp_q : LP_RESET;
   assign eligible = irr & ~imr;
   assign ack_edge = inta_q & ~inta_n;

   prio_encoder_rot u_req_enc (
      .vector (eligible),
      .lp     (lp_eff),
      .found  (req_found),
      .level  (req_level)
   );

   prio_encoder_rot u_isr_enc (
      .vector (isr),
      .lp     (lp_eff),
      .found  (isr_found),
      .level  (isr_level)
   );

   // State register and acknowledge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inta_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         inta_q  <= inta_n;
      end
   end

   // Next-state logic: edges in ACK2 are ignored, ACK2 always lasts one cycle.
   always_comb begin
      state_d    = state_q;
      enter_ack1 = 1'b0;
      enter_ack2 = 1'b0;
      case (state_q)
         IDLE: begin
            if (ack_edge) begin
               state_d    = ACK1;
               enter_ack1 = 1'b1;
            end
         end
         ACK1: begin
            if (ack_edge) begin
               state_d    = ACK2;
               enter_ack2 = 1'b1;
            end
         end
         ACK2:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // In-service set/clear masks and pointer update; clears see the pre-cycle isr, set wins.
   always_comb begin
      set_mask = 8'h00;
      clr_mask = 8'h00;
      lp_d     = lp_q;
      if (enter_ack1 && req_found) begin
         set_mask[req_level] = 1'b1;
      end
`ifdef ISR_AUTO_EOI_EN
      if (state_q == ACK2 && !spurious_q && isr[level_q]) begin
         clr_mask[level_q] = 1'b1;
         if (rotate_en) begin
            lp_d = level_q;
         end
      end
`endif
      if (eoi_valid) begin
         if (eoi_specific) begin
            if (isr[eoi_level]) begin
               clr_mask[eoi_level] = 1'b1;
               if (rotate_en) begin
                  lp_d = eoi_level;
               end
            end
         end else if (isr_found) begin
            clr_mask[isr_level] = 1'b1;
            if (rotate_en) begin
               lp_d = isr_level;
            end
         end
      end
   end

   // Request the CPU only in IDLE and only when the winner outranks everything in service.
   always_comb begin
      int_out_d = 1'b0;
      if (state_q == IDLE && !ack_edge && req_found) begin
         if (!isr_found) begin
            int_out_d = 1'b1;
         end else if (prio_rank(req_level, lp_eff) < prio_rank(isr_level, lp_eff)) begin
            int_out_d = 1'b1;
         end
      end
   end

   // In-service register and lowest-priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isr  <= 8'h00;
         lp_q <= LP_RESET;
      end else begin
         isr  <= (isr & ~clr_mask) | set_mask;
         lp_q <= lp_d;
      end
   end

   // Registered outputs and the level frozen at the first acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_out      <= 1'b0;
         irr_clear    <= 8'h00;
         vector_valid <= 1'b0;
         vector       <= 8'h00;
         level_q      <= 3'd0;
      end else begin
         int_out      <= int_out_d;
         irr_clear    <= set_mask;
         vector_valid <= enter_ack2;
         if (enter_ack1) begin
            level_q <= req_found ? req_level : SPURIOUS_LEVEL;
         end
         if (enter_ack2) begin
            vector <= {VECTOR_BASE, level_q};
         end
      end
   end

`ifdef ISR_AUTO_EOI_EN
   // Remember a spurious grant so auto EOI does not clear a genuine IR7.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spurious_q <= 1'b0;
      end else if (enter_ack1) begin
         spurious_q <= !req_found;
      end
   end
`endif

endmodule

// File: tb/tb_isr_priority_resolver.sv
// tb/tb_isr_priority_resolver.sv - scoreboard bench for isr_priority_resolver
module tb_isr_priority_resolver;

   localparam logic [4:0] BASE = 5'b00001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr, imr;
   logic       inta_n, eoi_valid, eoi_specific, rotate_en;
   logic [2:0] eoi_level;
   logic       int_out, vector_valid;
   logic [7:0] isr, irr_clear, vector;

   isr_priority_resolver #(.VECTOR_BASE(BASE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irr          (irr),
      .imr          (imr),
      .inta_n       (inta_n),
      .eoi_valid    (eoi_valid),
      .eoi_specific (eoi_specific),
      .eoi_level    (eoi_level),
      .rotate_en    (rotate_en),
      .int_out      (int_out),
      .isr          (isr),
      .irr_clear    (irr_clear),
      .vector_valid (vector_valid),
      .vector       (vector)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q_vec[$];
   logic [7:0] exp_v;
   logic [7:0] last_vec;
   logic [7:0] last_clear;

   logic [7:0] m_isr, m_clear;
   logic [2:0] m_lp, m_level;
   int         m_phase;
   logic       m_prev_inta, m_int_out, m_spur;

   function automatic int winner(input logic [7:0] m, input int lp);
      for (int k = 1; k <= 8; k++) begin
         int l;
         l = (lp + k) % 8;
         if (m[l]) return l;
      end
      return -1;
   endfunction

   function automatic int rank(input int l, input int lp);
      return (l - lp - 1 + 16) % 8;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_isr       = 8'h00;
      m_clear     = 8'h00;
      m_lp        = 3'd7;
      m_level     = 3'd0;
      m_phase     = 0;
      m_prev_inta = 1'b1;
      m_int_out   = 1'b0;
      m_spur      = 1'b0;
      q_vec.delete();
   endtask

   task automatic model_step();
      int         eff_lp, w, i;
      bit         ack;
      logic [7:0] set, clr;
      eff_lp = rotate_en ? int'(m_lp) : 7;
      ack    = m_prev_inta && !inta_n;
      w      = winner(irr & ~imr, eff_lp);
      i      = winner(m_isr, eff_lp);
      set    = 8'h00;
      clr    = 8'h00;
      m_int_out = (m_phase == 0) && !ack && (w >= 0) &&
                  ((i < 0) || (rank(w, eff_lp) < rank(i, eff_lp)));
      if (m_phase == 0) begin
         if (ack) begin
            m_phase = 1;
            m_spur  = (w < 0);
            m_level = m_spur ? 3'd7 : 3'(w);
            if (!m_spur) set[w] = 1'b1;
         end
      end else if (m_phase == 1) begin
         if (ack) begin
            m_phase = 2;
            q_vec.push_back({BASE, m_level});
         end
      end else begin
         m_phase = 0;
`ifdef ISR_AUTO_EOI_EN
         if (!m_spur && m_isr[m_level]) begin
            clr[m_level] = 1'b1;
            if (rotate_en) m_lp = m_level;
         end
`endif
      end
      if (eoi_valid) begin
         if (eoi_specific) begin
            if (m_isr[eoi_level]) begin
               clr[eoi_level] = 1'b1;
               if (rotate_en) m_lp = eoi_level;
            end
         end else if (i >= 0) begin
            clr[i] = 1'b1;
            if (rotate_en) m_lp = 3'(i);
         end
      end
      m_isr       = (m_isr & ~clr) | set;
      m_clear     = set;
      m_prev_inta = inta_n;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      inta_n    = 1'b1;
      eoi_valid = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic ack_pulse();
      inta_n = 1'b0;
      tick();
      inta_n = 1'b1;
      tick();
   endtask

   // Monitor: per-cycle state comparison and scoreboard pop on each vector strobe.
   always @(negedge clk) begin
      check("isr", isr, m_isr);
      check("int_out", {7'b0, int_out}, {7'b0, m_int_out});
      check("irr_clear", irr_clear, m_clear);
      if (irr_clear != 8'h00) last_clear = irr_clear;
      if (vector_valid) begin
         last_vec = vector;
         if (q_vec.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL vector_valid: unexpected strobe with vector %h, want none", vector);
         end else begin
            exp_v = q_vec.pop_front();
            check("vector", vector, exp_v);
         end
      end
   end

   initial begin
      rst_n = 1'b0; irr = 8'h00; imr = 8'h00; inta_n = 1'b1; eoi_valid = 1'b0;
      eoi_specific = 1'b0; eoi_level = 3'd0; rotate_en = 1'b0;
      last_vec = 8'h00; last_clear = 8'h00;
      model_reset();
      @(negedge clk); #1;
      do_reset();

      // Fixed mode grant of IR2.
      irr = 8'h24; imr = 8'h00; tick();
      check("int_out_fixed", {7'b0, int_out}, 8'h01);
      ack_pulse(); ack_pulse(); tick();
      check("clear_fixed", last_clear, 8'h04);
      check("vec_fixed", last_vec, 8'h0A);
`ifndef ISR_AUTO_EOI_EN
      check("isr_fixed", isr, 8'h04);
`else
      check("isr_auto", isr, 8'h00);
`endif

      // Masked IR2 lets IR5 win.
      do_reset();
      imr = 8'h04; irr = 8'h24; tick();
      ack_pulse(); ack_pulse(); tick();
      check("vec_masked", last_vec, 8'h0D);
`ifndef ISR_AUTO_EOI_EN
      check("isr_masked", isr, 8'h20);
`endif

      // Nesting: IR4 blocked by IR3 in service, IR1 gets through.
      do_reset();
      imr = 8'h00; irr = 8'h08; tick();
      ack_pulse(); ack_pulse(); tick();
      irr = 8'h10; tick(); tick();
`ifndef ISR_AUTO_EOI_EN
      check("nest_blocked", {7'b0, int_out}, 8'h00);
`endif
      irr = 8'h12; tick();
      check("nest_pass", {7'b0, int_out}, 8'h01);

      // Rotating: non-specific EOI moves lp to 0, then IR1 beats IR0.
      do_reset();
      rotate_en = 1'b1; irr = 8'h01; tick();
      ack_pulse(); ack_pulse(); tick();
      irr = 8'h00; eoi_valid = 1'b1; eoi_specific = 1'b0; tick();
      eoi_valid = 1'b0; tick();
      check("rot_eoi_isr", isr, 8'h00);
      irr = 8'h03; tick();
      ack_pulse(); ack_pulse(); tick();
      check("vec_rot", last_vec, 8'h09);

      // Spurious: request withdrawn before the first acknowledge.
      do_reset();
      rotate_en = 1'b0; irr = 8'h04; tick();
      irr = 8'h00; last_clear = 8'h00;
      ack_pulse(); ack_pulse(); tick();
      check("vec_spur", last_vec, 8'h0F);
      check("isr_spur", isr, 8'h00);
      check("clear_spur", last_clear, 8'h00);

      // Reset between acknowledge pulses abandons the cycle.
      do_reset();
      irr = 8'h02; tick();
      ack_pulse();
      rst_n = 1'b0; model_reset(); tick();
      check("isr_midrst", isr, 8'h00);
      rst_n = 1'b1; irr = 8'h00;
      tick(); tick(); tick();

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         irr          = 8'($urandom);
         imr          = 8'($urandom & $urandom);
         inta_n       = ($urandom % 3) != 0;
         eoi_valid    = ($urandom % 5) == 0;
         eoi_specific = $urandom % 2;
         eoi_level    = 3'($urandom % 8);
         rotate_en    = ((n / 150) % 2) == 1;
         if ($urandom % 200 == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end
      inta_n = 1'b1; eoi_valid = 1'b0;
      tick(); tick(); tick();
      check("vec_pending", 8'(q_vec.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
